// File: rtl/mp3_pkg.sv
// Shared definitions for the MP3 decoder serial data stream.
//   mp3_state_e     : stream controller states
//   MP3_WORD_W      : default bits per serial word
//   MP3_CLK_DIV     : default clk cycles per SCLK half-period
//   MP3_BURST       : default words per DREQ grant
package mp3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_NEXT,
        ST_GAP
    } mp3_state_e;

    localparam int unsigned MP3_WORD_W  = 8;
    localparam int unsigned MP3_CLK_DIV = 4;
    localparam int unsigned MP3_BURST   = 32;

endpackage

// File: rtl/mp3_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d     : asynchronous input
//   q     : synchronized output
module mp3_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/mp3_sdi_stream.sv
// Serial data streamer feeding an MP3 decoder SDI port in DREQ-gated bursts.
//   clk, rst_n : system clock, asynchronous active-low reset
//   s_valid    : upstream word available
//   s_data     : upstream word, shifted out MSB first
//   s_ready    : word accepted on an edge with s_valid && s_ready
//   dreq       : decoder data request (asynchronous)
//   sclk       : serial clock, idle low, data stable while high
//   sdata      : serial data
//   xdcs       : active-low data chip select
//   busy       : controller not idle
module mp3_sdi_stream
    import mp3_pkg::*;
#(
    parameter int unsigned WORD_W  = MP3_WORD_W,
    parameter int unsigned CLK_DIV = MP3_CLK_DIV,
    parameter int unsigned BURST   = MP3_BURST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [WORD_W-1:0] s_data,
    output logic              s_ready,
    input  logic              dreq,
    output logic              sclk,
    output logic              sdata,
    output logic              xdcs,
    output logic              busy
);

    localparam int unsigned BCW  = $clog2(BURST + 1);
    localparam int unsigned DCW  = $clog2(CLK_DIV + 1);
    localparam int unsigned BITW = $clog2(WORD_W);

    localparam logic [DCW-1:0]  DIV_LAST  = DCW'(CLK_DIV - 1);
    localparam logic [DCW-1:0]  DIV_ONE   = DCW'(1);
    localparam logic [BITW-1:0] BIT_LAST  = BITW'(WORD_W - 1);
    localparam logic [BITW-1:0] BIT_ONE   = BITW'(1);
    localparam logic [BCW-1:0]  BURST_LIM = BCW'(BURST);
    localparam logic [BCW-1:0]  BURST_ONE = BCW'(1);

    logic dreq_s;

    mp3_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dreq),
        .q     (dreq_s)
    );

    mp3_state_e        state_q, state_d;
    logic [DCW-1:0]    div_q, div_d;
    logic              phase_q, phase_d;    // 0: sclk low half, 1: sclk high half
    logic [BITW-1:0]   bit_q, bit_d;
    logic [BCW-1:0]    burst_q, burst_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [BCW-1:0]    burst_inc;

    assign burst_inc = burst_q + BURST_ONE;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        burst_d = burst_q;
        shift_d = shift_q;
        s_ready = 1'b0;
        xdcs    = 1'b1;
        sclk    = 1'b0;
        sdata   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dreq_s && s_valid) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                xdcs    = 1'b0;
                shift_d = s_data;
                bit_d   = '0;
                div_d   = '0;
                phase_d = 1'b0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                xdcs  = 1'b0;
                sclk  = phase_q;
                sdata = shift_q[WORD_W-1];
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        // End of the high half closes the bit.
                        phase_d = 1'b0;
                        shift_d = {shift_q[WORD_W-2:0], 1'b0};
                        bit_d   = bit_q + BIT_ONE;
                        if (bit_q == BIT_LAST) state_d = ST_NEXT;
                    end
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            ST_NEXT: begin
                // dreq_s is not re-checked here: a grant covers the whole burst.
                xdcs    = 1'b0;
                burst_d = burst_inc;
                div_d   = '0;
                if ((burst_inc < BURST_LIM) && s_valid) state_d = ST_LOAD;
                else                                    state_d = ST_GAP;
            end
            ST_GAP: begin
                burst_d = '0;
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            phase_q <= 1'b0;
            bit_q   <= '0;
            burst_q <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            burst_q <= burst_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: tb/tb_mp3_sdi_stream.sv
module tb_mp3_sdi_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WORD_W=8, CLK_DIV=2, BURST=4
    logic       a_valid = 1'b0, a_ready, a_dreq = 1'b0;
    logic [7:0] a_data = '0;
    logic       a_sclk, a_sdata, a_xdcs, a_busy;
    // Instance B: WORD_W=16, CLK_DIV=1, BURST=32
    logic        b_valid = 1'b0, b_ready, b_dreq = 1'b0;
    logic [15:0] b_data = '0;
    logic        b_sclk, b_sdata, b_xdcs, b_busy;

    mp3_sdi_stream #(.WORD_W(8), .CLK_DIV(2), .BURST(4)) u_a (
        .clk(clk), .rst_n(rst_n), .s_valid(a_valid), .s_data(a_data), .s_ready(a_ready),
        .dreq(a_dreq), .sclk(a_sclk), .sdata(a_sdata), .xdcs(a_xdcs), .busy(a_busy)
    );

    mp3_sdi_stream #(.WORD_W(16), .CLK_DIV(1), .BURST(32)) u_b (
        .clk(clk), .rst_n(rst_n), .s_valid(b_valid), .s_data(b_data), .s_ready(b_ready),
        .dreq(b_dreq), .sclk(b_sclk), .sdata(b_sdata), .xdcs(b_xdcs), .busy(b_busy)
    );

    int unsigned checks = 0;
    int unsigned failures = 0;

    logic [7:0]  a_src[$], a_exp[$];
    logic [15:0] b_src[$], b_exp[$];
    int unsigned a_bursts[$], a_gaps[$];
    int unsigned a_words = 0;
    bit a_en = 1'b0, b_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Upstream drivers: present queue head; on acceptance the word moves to the scoreboard.
    initial begin : drv_a
        bit hs;
        forever begin
            @(negedge clk);
            hs = a_valid && a_ready && rst_n;
            @(posedge clk);
            #1;
            if (hs) a_exp.push_back(a_src.pop_front());
            a_valid = a_en && (a_src.size() != 0);
            a_data  = a_valid ? a_src[0] : 8'($urandom);
        end
    end

    initial begin : drv_b
        bit hs;
        forever begin
            @(negedge clk);
            hs = b_valid && b_ready && rst_n;
            @(posedge clk);
            #1;
            if (hs) b_exp.push_back(b_src.pop_front());
            b_valid = b_en && (b_src.size() != 0);
            b_data  = b_valid ? b_src[0] : 16'($urandom);
        end
    end

    // Monitor A: sdata sampled on sclk rising edges; word time LOAD->next LOAD/GAP = 8*2*2+2.
    initial begin : mon_a
        logic [7:0] sh;
        int unsigned nb, cyc, hi, wr;
        bit inw;
        logic prev;
        sh = '0; nb = 0; cyc = 0; hi = 0; wr = 0; inw = 0; prev = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                nb = 0; inw = 0; prev = 0; wr = 0; hi = 0;
            end else begin
                if (inw) begin
                    cyc++;
                    if (a_ready || a_xdcs) begin
                        check("a_word_time", cyc, 34);
                        inw = 0;
                    end
                end
                if (a_ready) begin inw = 1; cyc = 0; end
                if (!a_xdcs && a_sclk && !prev) begin
                    sh = {sh[6:0], a_sdata};
                    nb++;
                    if (nb == 8) begin
                        nb = 0; wr++; a_words++;
                        check("a_exp_nonempty", a_exp.size() != 0, 1);
                        if (a_exp.size() != 0) check("a_word", sh, a_exp.pop_front());
                    end
                end
                if (a_xdcs) begin
                    nb = 0;
                    if (wr != 0) begin a_bursts.push_back(wr); wr = 0; end
                    hi++;
                end else if (hi != 0) begin
                    a_gaps.push_back(hi);
                    hi = 0;
                end
                prev = a_sclk;
            end
        end
    end

    // Monitor B: 16-bit words, sclk period must be 2 clk cycles inside a word.
    initial begin : mon_b
        logic [15:0] sh;
        int unsigned nb, cyc, t, last, viol;
        bit inw;
        logic prev;
        sh = '0; nb = 0; cyc = 0; t = 0; last = 0; viol = 0; inw = 0; prev = 0;
        forever begin
            @(negedge clk);
            t++;
            if (!rst_n) begin
                nb = 0; inw = 0; prev = 0; viol = 0;
            end else begin
                if (inw) begin
                    cyc++;
                    if (b_ready || b_xdcs) begin
                        check("b_word_time", cyc, 34);
                        inw = 0;
                    end
                end
                if (b_ready) begin inw = 1; cyc = 0; end
                if (!b_xdcs && b_sclk && !prev) begin
                    if (nb != 0 && (t - last) != 2) viol++;
                    last = t;
                    sh = {sh[14:0], b_sdata};
                    nb++;
                    if (nb == 16) begin
                        nb = 0;
                        check("b_sclk_period_viol", viol, 0);
                        viol = 0;
                        check("b_exp_nonempty", b_exp.size() != 0, 1);
                        if (b_exp.size() != 0) check("b_word", sh, b_exp.pop_front());
                    end
                end
                if (b_xdcs) nb = 0;
                prev = b_sclk;
            end
        end
    end

    task automatic wait_a_idle(input string name);
        int unsigned n = 0;
        do begin @(negedge clk); n++; end
        while ((a_busy || a_src.size() != 0 || a_valid) && n < 3000);
        check(name, n < 3000, 1);
        repeat (4) @(negedge clk);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int unsigned n, viol;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_sclk", a_sclk, 0);
        check("rst_sdata", a_sdata, 0);
        check("rst_xdcs", a_xdcs, 1);
        check("rst_s_ready", a_ready, 0);
        check("rst_busy", a_busy, 0);
        check("rst_b_xdcs", b_xdcs, 1);
        rst_n = 1'b1;

        // dreq low with data waiting: outputs static, then LOAD three edges after dreq rises
        a_en = 1'b1;
        a_src.push_back(8'hA5);
        viol = 0;
        for (int unsigned i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_ready !== 1'b0 || a_sclk !== 1'b0 || a_xdcs !== 1'b1) viol++;
        end
        check("idle_static_viol", viol, 0);
        check("idle_valid_seen", a_valid, 1);
        a_dreq = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!a_ready && n < 20);
        check("dreq_to_load", n, 3);
        wait_a_idle("a5_done");
        check("a5_burst_len", a_bursts.size() != 0 ? a_bursts[a_bursts.size()-1] : 0, 1);

        // Six words, BURST=4: split 4 + 2 with GAP(2)+IDLE(1) xdcs-high cycles between
        a_bursts.delete();
        a_gaps.delete();
        a_src = '{8'h00, 8'hFF, 8'h5A, 8'h81, 8'h7E, 8'hC3};
        wait_a_idle("burst6_done");
        check("burst6_count", a_bursts.size(), 2);
        check("burst6_first", a_bursts.size() > 0 ? a_bursts[0] : 0, 4);
        check("burst6_second", a_bursts.size() > 1 ? a_bursts[1] : 0, 2);
        check("burst6_gap", a_gaps.size() > 1 ? a_gaps[1] : 0, 3);

        // Starvation after word 2: burst ends, s_ready waits for fresh data
        a_bursts.delete();
        a_src = '{8'hC1, 8'hC2};
        wait_a_idle("starve_done");
        viol = 0;
        for (int unsigned i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a_ready !== 1'b0 || a_xdcs !== 1'b1) viol++;
        end
        check("starve_static_viol", viol, 0);
        check("starve_busy", a_busy, 0);
        a_src.push_back(8'h3E);
        wait_a_idle("resume_done");
        check("starve_bursts", a_bursts.size(), 2);
        check("starve_first", a_bursts.size() > 0 ? a_bursts[0] : 0, 2);
        check("starve_second", a_bursts.size() > 1 ? a_bursts[1] : 0, 1);

        // Reset during bit 3 of 0x3C: immediate abort, no retransmission
        a_src.push_back(8'h3C);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!a_ready && n < 50);
        check("rst_word_load", a_ready, 1);
        repeat (14) @(posedge clk);
        #2;
        check("pre_rst_xdcs", a_xdcs, 0);
        rst_n = 1'b0;
        #1;
        check("abort_xdcs", a_xdcs, 1);
        check("abort_sclk", a_sclk, 0);
        check("abort_sdata", a_sdata, 0);
        check("abort_busy", a_busy, 0);
        repeat (3) @(negedge clk);
        check("abort_pending", a_exp.size(), 1);
        a_exp.delete();
        rst_n = 1'b1;
        n = a_words;
        viol = 0;
        for (int unsigned i = 0; i < 60; i++) begin
            @(negedge clk);
            if (a_ready !== 1'b0 || a_busy !== 1'b0) viol++;
        end
        check("no_retx_viol", viol, 0);
        check("no_retx_words", a_words, n);

        // 16-bit words at CLK_DIV=1
        b_en = 1'b1;
        b_dreq = 1'b1;
        b_src = '{16'h8001, 16'h7FFE};
        n = 0;
        do begin @(negedge clk); n++; end
        while ((b_busy || b_src.size() != 0 || b_valid) && n < 3000);
        check("b_done", n < 3000, 1);
        repeat (4) @(negedge clk);

        check("a_pending_end", a_exp.size(), 0);
        check("b_pending_end", b_exp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mp3_sdi_stream.md
MP3_SDI_STREAM -- requirements
Module: mp3_sdi_stream

Interface
REQ-001 Parameter WORD_W, 8, bits per serial word; legal values 8 or 16.
REQ-002 Parameter CLK_DIV, 4, clk cycles per SCLK half-period; legal range 1..255.
REQ-003 Parameter BURST, 32, words sent per DREQ grant; legal range 1..1024.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 s_valid  input  1  upstream word available.
REQ-007 s_data  input  WORD_W  upstream word, sent MSB first.
REQ-008 s_ready  output  1  word accepted on the clk edge where s_valid&&s_ready.
REQ-009 dreq  input  1  decoder data request; asynchronous to clk.
REQ-010 sclk  output  1  serial clock to decoder; idle low.
REQ-011 sdata  output  1  serial data to decoder.
REQ-012 xdcs  output  1  active-low data chip select.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 dreq SHALL pass through a 2-FF synchronizer; only dreq_s is used internally.
REQ-015 FSM states SHALL be IDLE, LOAD, SHIFT, NEXT and GAP.
REQ-016 IDLE: s_ready=0, xdcs=1; go to LOAD when dreq_s=1 and s_valid=1.
REQ-017 LOAD: s_ready=1 for exactly one cycle; capture s_data into the shift register; drive xdcs=0; clear bit counter; go to SHIFT.
REQ-018 SHIFT: each bit lasts 2*CLK_DIV clk cycles; sdata = current MSB during the whole bit; sclk low for the first CLK_DIV cycles and high for the next CLK_DIV; shift left at the end of the bit.
REQ-019 Word time SHALL be exactly WORD_W*2*CLK_DIV clk cycles from the LOAD cycle+1 to NEXT entry.
REQ-020 NEXT (one cycle, sclk=0, xdcs=0): increment burst counter; if count<BURST and s_valid=1, go to LOAD; otherwise go to GAP.
REQ-021 GAP: xdcs=1, sclk=0 for CLK_DIV cycles; clear burst counter; go to IDLE.
REQ-022 Upstream starvation mid-burst SHALL end the burst via GAP; the next word waits for a fresh dreq_s check.
REQ-023 dreq_s falling mid-word SHALL NOT truncate the word or the current burst.
REQ-024 s_ready SHALL never be high outside LOAD; s_data SHALL be ignored when s_ready=0.
REQ-025 Burst counter width SHALL be $clog2(BURST+1); divider counter width $clog2(CLK_DIV+1).

Reset
REQ-026 While rst_n=0: state=IDLE, sclk=0, sdata=0, xdcs=1, s_ready=0, busy=0, all counters and the shift register cleared, synchronizer flops 0.
REQ-027 Reset asserted mid-word SHALL abort immediately with xdcs=1; no partial word resumes after release.
REQ-028 First LOAD after reset release SHALL require two clk edges of synchronized dreq=1.

Structure
REQ-029 Shared package mp3_pkg SHALL hold the state enumeration and the default values for WORD_W, CLK_DIV and BURST.
REQ-030 One sub-module, mp3_sync2, SHALL implement the 2-FF dreq synchronizer (reset to 0).
REQ-031 Divider, bit counter, burst counter, shift register and FSM SHALL be local to mp3_sdi_stream.

Verification
REQ-032 WORD_W=8, CLK_DIV=2, dreq=1, send 0xA5 -> sdata bits 1,0,1,0,0,1,0,1 sampled on sclk rising edges; xdcs low 32+ cycles; 8 sclk pulses.
REQ-033 BURST=4, dreq=1, 6 words always valid -> 4 words, xdcs high for 2 cycles, IDLE, then words 5 and 6 in a second burst.
REQ-034 s_valid dropped after word 2 of a BURST=32 burst -> GAP entered, xdcs high, s_ready stays 0 until s_valid and dreq_s both high again.
REQ-035 dreq=0 with s_valid=1 -> s_ready, sclk and xdcs static (0, 0, 1) for 100 cycles; dreq rises -> LOAD exactly 3 clk later.
REQ-036 rst_n pulsed low during bit 3 of word 0x3C -> xdcs=1, sclk=0, sdata=0 same cycle; after release, 0x3C not retransmitted unless re-presented.
REQ-037 WORD_W=16, CLK_DIV=1, word 0x8001 -> 16 sclk pulses of 2-cycle period, first and last bits 1, others 0.
